// File: rtl/dmac_pkg.sv
// Shared DMAC write-side definitions: register addresses, STATUS bit positions, descriptor payload.
package dmac_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned ADDR_W = 3;
  localparam int unsigned CNT_W  = 4;

  localparam logic [ADDR_W-1:0] ADDR_START  = 3'd0;
  localparam logic [ADDR_W-1:0] ADDR_INT    = 3'd1;
  localparam logic [ADDR_W-1:0] ADDR_INT_EN = 3'd2;
  localparam logic [ADDR_W-1:0] ADDR_SRC    = 3'd3;
  localparam logic [ADDR_W-1:0] ADDR_DEST   = 3'd4;
  localparam logic [ADDR_W-1:0] ADDR_SIZE   = 3'd5;
  localparam logic [ADDR_W-1:0] ADDR_PUSH   = 3'd6;
  localparam logic [ADDR_W-1:0] ADDR_STATUS = 3'd7;

  // STATUS layout; bit 5 reports a non-empty FIFO so the register reads 0 out of reset
  localparam int unsigned STAT_OVF_BIT   = 7;
  localparam int unsigned STAT_BUSY_BIT  = 6;
  localparam int unsigned STAT_VALID_BIT = 5;

  typedef struct packed {
    logic [DATA_W-1:0] src;
    logic [DATA_W-1:0] dest;
    logic [DATA_W-1:0] size;
  } desc_t;

endpackage

// File: rtl/dmac_write_operation_if.sv
// Slave register write bus of the DMAC.
interface dmac_write_operation_if;
  import dmac_pkg::*;

  logic              s_sel;
  logic              s_wr;
  logic [ADDR_W-1:0] s_addr;
  logic [DATA_W-1:0] s_din;

  modport master (output s_sel, output s_wr, output s_addr, output s_din);
  modport slave  (input  s_sel, input  s_wr, input  s_addr, input  s_din);
endinterface

// File: rtl/dmac_desc_fifo.sv
// Synchronous descriptor FIFO; head entry presented combinationally, zero when empty.
module dmac_desc_fifo
  import dmac_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic             pop,
  input  desc_t            wdata,
  output desc_t            rdata,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  desc_t            mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign pop_ok  = pop & ~empty;
  // a full FIFO still accepts a push when the head leaves in the same cycle
  assign push_ok = push & (~full | pop_ok);
  assign rdata   = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop_ok) rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/dmac_write_operation.sv
// DMAC register write side: control registers, start pulse, descriptor FIFO, done interrupt.
// Optional macro DMAC_WR_PROTECT_EN blocks SRC/DEST/SIZE/PUSH writes while busy.
module dmac_write_operation
  import dmac_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  dmac_write_operation_if.slave  bus,
  input  logic                   op_done,
  input  logic                   desc_ready,
  output logic                   desc_valid,
  output logic [DATA_W-1:0]      desc_src,
  output logic [DATA_W-1:0]      desc_dest,
  output logic [DATA_W-1:0]      desc_size,
  output logic                   op_start,
  output logic                   irq,
  output logic [DATA_W-1:0]      to_reg0,
  output logic [DATA_W-1:0]      to_reg1,
  output logic [DATA_W-1:0]      to_reg2,
  output logic [DATA_W-1:0]      to_reg3,
  output logic [DATA_W-1:0]      to_reg4,
  output logic [DATA_W-1:0]      to_reg5,
  output logic [DATA_W-1:0]      to_reg6,
  output logic [DATA_W-1:0]      to_reg7
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  logic [0:0]        state;
  logic [0:0]        state_nxt;
  logic              start_c;
  logic              busy;
  logic              int_flag;
  logic              int_en;
  logic              overflow;
  logic [DATA_W-1:0] src_q;
  logic [DATA_W-1:0] dest_q;
  logic [DATA_W-1:0] size_q;
  logic              wr_en;
  logic              stage_ok;
  logic              push_req;
  logic              pop_req;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CNT_W-1:0]  fifo_count;
  desc_t             push_desc;
  desc_t             head_desc;
  logic [DATA_W-1:0] status_c;

  assign wr_en = bus.s_sel & bus.s_wr;
  assign busy  = (state == ST_BUSY);

`ifdef DMAC_WR_PROTECT_EN
  assign stage_ok = ~busy;
`else
  assign stage_ok = 1'b1;
`endif

  assign push_req  = wr_en & (bus.s_addr == ADDR_PUSH) & bus.s_din[0] & stage_ok;
  assign pop_req   = desc_valid & desc_ready;
  assign push_desc = '{src: src_q, dest: dest_q, size: size_q};

  dmac_desc_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push_req),
    .pop     (pop_req),
    .wdata   (push_desc),
    .rdata   (head_desc),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  // transfer state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  // START is only honoured when idle with a descriptor waiting
  always_comb begin
    state_nxt = state;
    start_c   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (wr_en && (bus.s_addr == ADDR_START) && bus.s_din[0] && desc_valid) begin
          start_c   = 1'b1;
          state_nxt = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (op_done) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // control and staging registers; a done pulse beats a same-cycle INT clear
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op_start <= 1'b0;
      int_flag <= 1'b0;
      int_en   <= 1'b0;
      overflow <= 1'b0;
      src_q    <= '0;
      dest_q   <= '0;
      size_q   <= '0;
    end else begin
      op_start <= start_c;
      if (op_done)                                               int_flag <= 1'b1;
      else if (wr_en && (bus.s_addr == ADDR_INT) && bus.s_din[0]) int_flag <= 1'b0;
      if (wr_en && (bus.s_addr == ADDR_INT_EN))                   int_en   <= bus.s_din[0];
      if (wr_en && stage_ok && (bus.s_addr == ADDR_SRC))          src_q    <= bus.s_din;
      if (wr_en && stage_ok && (bus.s_addr == ADDR_DEST))         dest_q   <= bus.s_din;
      if (wr_en && stage_ok && (bus.s_addr == ADDR_SIZE))         size_q   <= bus.s_din;
      if (push_req && fifo_full && !pop_req)                      overflow <= 1'b1;
      else if (wr_en && (bus.s_addr == ADDR_STATUS) && bus.s_din[7]) overflow <= 1'b0;
    end
  end

  always_comb begin
    status_c                 = '0;
    status_c[STAT_OVF_BIT]   = overflow;
    status_c[STAT_BUSY_BIT]  = busy;
    status_c[STAT_VALID_BIT] = desc_valid;
    status_c[CNT_W-1:0]      = fifo_count;
  end

  assign desc_valid = ~fifo_empty;
  assign desc_src   = head_desc.src;
  assign desc_dest  = head_desc.dest;
  assign desc_size  = head_desc.size;
  assign irq        = int_flag & int_en;

  assign to_reg0 = {7'b0, busy};
  assign to_reg1 = {7'b0, int_flag};
  assign to_reg2 = {7'b0, int_en};
  assign to_reg3 = src_q;
  assign to_reg4 = dest_q;
  assign to_reg5 = size_q;
  assign to_reg6 = '0;
  assign to_reg7 = status_c;

endmodule

// File: tb/tb_dmac_write_operation.sv
// Directed self-checking bench for dmac_write_operation (FIFO_DEPTH = 4).
module tb_dmac_write_operation;
  import dmac_pkg::*;

  logic       clk;
  logic       reset_n;
  logic       op_done;
  logic       desc_ready;
  logic       desc_valid;
  logic [7:0] desc_src, desc_dest, desc_size;
  logic       op_start;
  logic       irq;
  logic [7:0] to_reg0, to_reg1, to_reg2, to_reg3, to_reg4, to_reg5, to_reg6, to_reg7;

  int nvec = 0;
  int nerr = 0;

  dmac_write_operation_if bus ();

  dmac_write_operation #(.FIFO_DEPTH(4)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .bus        (bus),
    .op_done    (op_done),
    .desc_ready (desc_ready),
    .desc_valid (desc_valid),
    .desc_src   (desc_src),
    .desc_dest  (desc_dest),
    .desc_size  (desc_size),
    .op_start   (op_start),
    .irq        (irq),
    .to_reg0    (to_reg0),
    .to_reg1    (to_reg1),
    .to_reg2    (to_reg2),
    .to_reg3    (to_reg3),
    .to_reg4    (to_reg4),
    .to_reg5    (to_reg5),
    .to_reg6    (to_reg6),
    .to_reg7    (to_reg7)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    bus.s_sel  = 1'b1;
    bus.s_wr   = 1'b1;
    bus.s_addr = a;
    bus.s_din  = d;
    tick();
    bus.s_sel  = 1'b0;
    bus.s_wr   = 1'b0;
  endtask

  task automatic pulse_done();
    op_done = 1'b1;
    tick();
    op_done = 1'b0;
  endtask

  logic [7:0] order [4];

  initial begin
    reset_n    = 1'b0;
    op_done    = 1'b0;
    desc_ready = 1'b0;
    bus.s_sel  = 1'b0;
    bus.s_wr   = 1'b0;
    bus.s_addr = '0;
    bus.s_din  = '0;
    tick();
    tick();
    check("rst_status", to_reg7, 8'h00);
    check("rst_valid", {7'b0, desc_valid}, 8'h00);
    reset_n = 1'b1;
    tick();

    // writes without both select and strobe do nothing
    bus.s_sel = 1'b0; bus.s_wr = 1'b1; bus.s_addr = ADDR_SRC; bus.s_din = 8'hFF;
    tick();
    check("nosel_src", to_reg3, 8'h00);
    bus.s_sel = 1'b1; bus.s_wr = 1'b0;
    tick();
    check("nowr_src", to_reg3, 8'h00);
    bus.s_sel = 1'b0;

    // T2 staging and push
    wr(ADDR_SRC, 8'h12);
    wr(ADDR_DEST, 8'h34);
    wr(ADDR_SIZE, 8'h05);
    check("src_rb", to_reg3, 8'h12);
    check("dest_rb", to_reg4, 8'h34);
    check("size_rb", to_reg5, 8'h05);
    check("pre_push_valid", {7'b0, desc_valid}, 8'h00);
    wr(ADDR_PUSH, 8'h01);
    check("push_valid", {7'b0, desc_valid}, 8'h01);
    check("push_src", desc_src, 8'h12);
    check("push_dest", desc_dest, 8'h34);
    check("push_size", desc_size, 8'h05);
    check("push_status", to_reg7, 8'h21);
    check("push_rb", to_reg6, 8'h00);

    // T3 start pulse
    wr(ADDR_START, 8'h01);
    check("start_pulse", {7'b0, op_start}, 8'h01);
    check("start_busy", to_reg0, 8'h01);
    check("start_status", to_reg7, 8'h61);
    tick();
    check("start_pulse_end", {7'b0, op_start}, 8'h00);
    wr(ADDR_START, 8'h01);
    check("restart_busy", {7'b0, op_start}, 8'h00);
    tick();
    check("restart_busy2", {7'b0, op_start}, 8'h00);
    pulse_done();
    check("done_busy", to_reg0, 8'h00);
    check("done_flag", to_reg1, 8'h01);
    check("done_irq_masked", {7'b0, irq}, 8'h00);
    desc_ready = 1'b1;
    tick();
    desc_ready = 1'b0;
    check("pop_valid", {7'b0, desc_valid}, 8'h00);
    check("pop_src_zero", desc_src, 8'h00);
    wr(ADDR_START, 8'h01);
    check("start_empty", {7'b0, op_start}, 8'h00);
    check("start_empty_busy", to_reg0, 8'h00);

    // T4 interrupt
    wr(ADDR_INT_EN, 8'h01);
    check("inten_rb", to_reg2, 8'h01);
    check("irq_on", {7'b0, irq}, 8'h01);
    wr(ADDR_INT, 8'h01);
    check("int_clr", to_reg1, 8'h00);
    check("irq_clr", {7'b0, irq}, 8'h00);
    pulse_done();
    check("irq_done", {7'b0, irq}, 8'h01);
    wr(ADDR_INT, 8'h01);
    check("irq_clr2", {7'b0, irq}, 8'h00);
    op_done = 1'b1;
    wr(ADDR_INT, 8'h01);
    op_done = 1'b0;
    check("set_wins_flag", to_reg1, 8'h01);
    check("set_wins_irq", {7'b0, irq}, 8'h01);

    // T6 staging writes while busy
    wr(ADDR_SRC, 8'h55);
    wr(ADDR_PUSH, 8'h01);
    wr(ADDR_START, 8'h01);
    check("t6_start", {7'b0, op_start}, 8'h01);
    wr(ADDR_SRC, 8'hAA);
    wr(ADDR_PUSH, 8'h01);
`ifdef DMAC_WR_PROTECT_EN
    check("t6_src_busy", to_reg3, 8'h55);
    check("t6_status", to_reg7, 8'h61);
`else
    check("t6_src_busy", to_reg3, 8'hAA);
    check("t6_status", to_reg7, 8'h62);
`endif
    check("t6_head", desc_src, 8'h55);
    pulse_done();
    desc_ready = 1'b1;
    tick();
    tick();
    desc_ready = 1'b0;
    check("t6_drained", to_reg7, 8'h00);

    // T5 fill, overflow, clear, full push+pop
    for (int i = 0; i < 4; i++) begin
      wr(ADDR_SRC, 8'(8'h10 + i));
      wr(ADDR_PUSH, 8'h01);
    end
    check("full_status", to_reg7, 8'h24);
    wr(ADDR_SRC, 8'h14);
    wr(ADDR_PUSH, 8'h01);
    check("ovf_status", to_reg7, 8'hA4);
    check("ovf_head", desc_src, 8'h10);
    wr(ADDR_STATUS, 8'h00);
    check("ovf_keep", to_reg7, 8'hA4);
    wr(ADDR_STATUS, 8'h80);
    check("ovf_clear", to_reg7, 8'h24);
    wr(ADDR_SRC, 8'h20);
    desc_ready = 1'b1;
    wr(ADDR_PUSH, 8'h01);
    desc_ready = 1'b0;
    check("full_pushpop", to_reg7, 8'h24);
    order[0] = 8'h11; order[1] = 8'h12; order[2] = 8'h13; order[3] = 8'h20;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("order%0d", i), desc_src, order[i]);
      desc_ready = 1'b1;
      tick();
      desc_ready = 1'b0;
    end
    check("final_empty", to_reg7, 8'h00);
    check("final_src", desc_src, 8'h00);

    // T1 reset mid-transfer
    pulse_done();
    wr(ADDR_SRC, 8'h77);
    wr(ADDR_PUSH, 8'h01);
    wr(ADDR_START, 8'h01);
    check("t1_pulse", {7'b0, op_start}, 8'h01);
    check("t1_irq_pre", {7'b0, irq}, 8'h01);
    #2;
    reset_n = 1'b0;
    #1;
    check("t1_op_start", {7'b0, op_start}, 8'h00);
    check("t1_irq", {7'b0, irq}, 8'h00);
    check("t1_valid", {7'b0, desc_valid}, 8'h00);
    check("t1_src", desc_src, 8'h00);
    check("t1_reg0", to_reg0, 8'h00);
    check("t1_reg1", to_reg1, 8'h00);
    check("t1_reg2", to_reg2, 8'h00);
    check("t1_reg3", to_reg3, 8'h00);
    check("t1_reg4", to_reg4, 8'h00);
    check("t1_reg5", to_reg5, 8'h00);
    check("t1_reg6", to_reg6, 8'h00);
    check("t1_reg7", to_reg7, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
